var_delay_line: RTL and testbench
=================================

VAR_DELAY_LINE -- requirements
Module: var_delay_line

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of register stages (>=2).
REQ-003 SHALL have parameter SEL_W, default 4, tap-select width; SEL_W SHALL be >= clog2(DEPTH).
REQ-004 SHALL have port clk_100M, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port en, input, 1, shift/rotate enable for the current cycle.
REQ-007 SHALL have port rot, input, 1, mode: 0 = shift in din, 1 = rotate the chain.
REQ-008 SHALL have port flush, input, 1, synchronous clear of data, valid flags and fill count.
REQ-009 SHALL have port din, input, DATA_W, write data into stage 0.
REQ-010 SHALL have port din_valid, input, 1, valid tag that travels with din.
REQ-011 SHALL have port delay_sel, input, SEL_W, output tap index.
REQ-012 SHALL have port dout, output, DATA_W, data at the selected tap.
REQ-013 SHALL have port dout_valid, output, 1, valid tag at the selected tap.
REQ-014 SHALL have port fill_cnt, output, SEL_W+1, enabled shifts since reset/flush, saturating at DEPTH.
REQ-015 SHALL have port full, output, 1, high when fill_cnt == DEPTH.

Function
REQ-016 SHALL hold DEPTH data stages stg[0..DEPTH-1] (DATA_W each) and DEPTH valid flags vld[0..DEPTH-1].
REQ-017 Shift: when en=1, rot=0 and flush=0, SHALL load stg[0]<=din, vld[0]<=din_valid, and stg[k]<=stg[k-1], vld[k]<=vld[k-1] for k=1..DEPTH-1.
REQ-018 Rotate: when en=1, rot=1 and flush=0, SHALL load stg[0]<=stg[DEPTH-1], vld[0]<=vld[DEPTH-1], and shift the others as in REQ-017; din and din_valid are ignored.
REQ-019 Hold: when en=0 and flush=0, all stages, flags and fill_cnt SHALL keep their values.
REQ-020 Tap: dout SHALL equal stg[t] and dout_valid SHALL equal vld[t], combinationally. t = delay_sel if delay_sel < DEPTH, else t = DEPTH-1 (clamped).
REQ-021 Latency: a word shifted in on an enabled edge SHALL appear on dout after exactly delay_sel+1 enabled edges. Disabled cycles do not count.
REQ-022 Changing delay_sel SHALL take effect on dout in the same cycle, with no pipeline bubble.
REQ-023 fill_cnt SHALL increment by 1 on each shift edge (REQ-017) while below DEPTH. It SHALL stay unchanged on rotate or hold edges, and saturate at DEPTH.
REQ-024 full SHALL be driven combinationally from fill_cnt.
REQ-025 Flush: when flush=1, SHALL clear all stg to 0, all vld to 0, and fill_cnt to 0 on that edge, regardless of en and rot.
REQ-026 Priority SHALL be: rst > flush > en (shift or rotate) > hold.
REQ-027 Data and valid SHALL never be modified except by REQ-017, REQ-018, REQ-025 or reset. Data is passed through unaltered, with no arithmetic.

Reset
REQ-028 On a rising edge with rst=1, SHALL set all stg to 0, all vld to 0, and fill_cnt to 0. All other inputs are ignored.
REQ-029 In the cycle after reset: dout=0, dout_valid=0, fill_cnt=0, full=0.
REQ-030 Reset asserted mid-operation SHALL discard all buffered words. The first post-reset shift SHALL behave identically to the first shift after power-up reset.

Verification
REQ-031 Bench SHALL cover fixed delay: DEPTH=16, delay_sel=3, en=1, rot=0, din=0x01,0x02,... with din_valid=1 -> dout=0x01 with dout_valid=1 on the 4th edge; dout_valid=0 before that.
REQ-032 Bench SHALL cover stall: delay_sel=0, shift 0xA5, then en=0 for 5 cycles -> dout holds 0xA5 and fill_cnt holds 1 throughout.
REQ-033 Bench SHALL cover fill and clamp: 20 consecutive shifts -> fill_cnt reaches 16 and stays 16, and full=1 from the 16th edge. With delay_sel=15, dout equals the word from 16 shifts earlier.
REQ-034 Bench SHALL cover rotate: fill 16 words 0x00..0x0F, then rot=1, en=1 for 16 edges -> chain returns to its original contents, with stg[15] back to 0x00, fill_cnt=16, and din values ignored.
REQ-035 Bench SHALL cover flush vs enable: flush=1 with en=1, din=0xFF, din_valid=1 on the same edge -> next cycle all taps read 0, dout_valid=0, fill_cnt=0.
REQ-036 Bench SHALL cover reset mid-stream: rst=1 for one edge after 7 shifts -> dout=0, dout_valid=0, fill_cnt=0. A subsequent shift of 0x3C with delay_sel=0 -> dout=0x3C, fill_cnt=1.

Source files
------------

// File: rtl/var_delay_line.sv
// Variable-length delay line: a DEPTH-stage data/valid shift chain with a
// selectable output tap, rotate mode, synchronous flush and a saturating
// fill counter.
module var_delay_line #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int SEL_W  = 4
) (
    input  logic              clk_100M,
    input  logic              rst,
    input  logic              en,
    input  logic              rot,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic [SEL_W-1:0]  delay_sel,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [SEL_W:0]    fill_cnt,
    output logic              full
);

    // DEPTH expressed at fill-counter width so compares stay width-matched.
    localparam logic [SEL_W:0]   DEPTH_C  = (SEL_W+1)'(DEPTH);
    localparam logic [SEL_W-1:0] LAST_TAP = SEL_W'(DEPTH - 1);

    logic [DATA_W-1:0] stg_r [DEPTH];
    logic              vld_r [DEPTH];
    logic [SEL_W:0]    fill_cnt_r;
    logic [SEL_W-1:0]  tap_s;
    logic [DATA_W-1:0] dout_s;
    logic              dout_valid_s;

    // Chain update: reset, then flush, then shift/rotate, otherwise hold.
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stg_r[k] <= {DATA_W{1'b0}};
                vld_r[k] <= 1'b0;
            end
            fill_cnt_r <= {(SEL_W+1){1'b0}};
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                stg_r[k] <= {DATA_W{1'b0}};
                vld_r[k] <= 1'b0;
            end
            fill_cnt_r <= {(SEL_W+1){1'b0}};
        end else if (en) begin
            // Stage 0 takes new input in shift mode, the last stage in rotate mode.
            if (rot) begin
                stg_r[0] <= stg_r[DEPTH-1];
                vld_r[0] <= vld_r[DEPTH-1];
            end else begin
                stg_r[0] <= din;
                vld_r[0] <= din_valid;
            end
            for (int k = 1; k < DEPTH; k++) begin
                stg_r[k] <= stg_r[k-1];
                vld_r[k] <= vld_r[k-1];
            end
            // Only genuine shifts add new words; rotation just recirculates.
            if (!rot && (fill_cnt_r < DEPTH_C)) begin
                fill_cnt_r <= fill_cnt_r + {{SEL_W{1'b0}}, 1'b1};
            end else begin
                fill_cnt_r <= fill_cnt_r;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stg_r[k] <= stg_r[k];
                vld_r[k] <= vld_r[k];
            end
            fill_cnt_r <= fill_cnt_r;
        end
    end

    // Clamp out-of-range tap selections to the last stage.
    always_comb begin
        if ({1'b0, delay_sel} < DEPTH_C) begin
            tap_s = delay_sel;
        end else begin
            tap_s = LAST_TAP;
        end
    end

    // Output tap multiplexer; combinational so a new delay_sel acts immediately.
    always_comb begin
        dout_s       = {DATA_W{1'b0}};
        dout_valid_s = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (tap_s == SEL_W'(k)) begin
                dout_s       = stg_r[k];
                dout_valid_s = vld_r[k];
            end else begin
                dout_s       = dout_s;
                dout_valid_s = dout_valid_s;
            end
        end
    end

    assign dout       = dout_s;
    assign dout_valid = dout_valid_s;
    assign fill_cnt   = fill_cnt_r;
    assign full       = (fill_cnt_r == DEPTH_C);

endmodule

// File: tb/tb_var_delay_line.sv
// Directed, table-driven bench for var_delay_line (default parameters).
module tb_var_delay_line;

    logic       clk_100M = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       rot = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic [3:0] delay_sel = 4'd0;
    logic [7:0] dout;
    logic       dout_valid;
    logic [4:0] fill_cnt;
    logic       full;

    int errors = 0;
    int checks = 0;

    var_delay_line #(.DATA_W(8), .DEPTH(16), .SEL_W(4)) dut (
        .clk_100M  (clk_100M),
        .rst       (rst),
        .en        (en),
        .rot       (rot),
        .flush     (flush),
        .din       (din),
        .din_valid (din_valid),
        .delay_sel (delay_sel),
        .dout      (dout),
        .dout_valid(dout_valid),
        .fill_cnt  (fill_cnt),
        .full      (full)
    );

    always #5 clk_100M = ~clk_100M;

    typedef struct {
        logic       rst;
        logic       flush;
        logic       en;
        logic       rot;
        logic [7:0] din;
        logic       dv;
        logic [3:0] sel;
        logic [7:0] e_dout;
        logic       e_dv;
        logic [4:0] e_fill;
        logic       e_full;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_100M);
        #1;
    endtask

    task automatic drive(input logic r, input logic f, input logic e, input logic ro,
                         input logic [7:0] d, input logic v, input logic [3:0] s);
        rst = r; flush = f; en = e; rot = ro; din = d; din_valid = v; delay_sel = s;
    endtask

    task automatic chk_all(input string nm, input logic [7:0] ed, input logic ev,
                           input logic [4:0] ef, input logic efu);
        chk({nm, ".dout"},       int'(dout),       int'(ed));
        chk({nm, ".dout_valid"}, int'(dout_valid), int'(ev));
        chk({nm, ".fill_cnt"},   int'(fill_cnt),   int'(ef));
        chk({nm, ".full"},       int'(full),       int'(efu));
    endtask

    // Walk every tap while the chain is held; all must read zero / invalid.
    task automatic scan_zero(input string nm);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        for (int k = 0; k < 16; k++) begin
            delay_sel = 4'(k);
            #1;
            chk($sformatf("%s.tap%0d", nm, k), int'(dout), 0);
            chk($sformatf("%s.vld%0d", nm, k), int'(dout_valid), 0);
        end
    endtask

    initial begin
        // fields: rst flush en rot din dv sel | dout dv fill full
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd3, 8'h00, 1'b0, 5'd0, 1'b0});
        // fixed delay of 3: first word appears on the 4th shift
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 4'd3, 8'h00, 1'b0, 5'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 1'b1, 4'd3, 8'h00, 1'b0, 5'd2, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 1'b1, 4'd3, 8'h00, 1'b0, 5'd3, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 1'b1, 4'd3, 8'h01, 1'b1, 5'd4, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 1'b1, 4'd3, 8'h02, 1'b1, 5'd5, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h06, 1'b1, 4'd3, 8'h03, 1'b1, 5'd6, 1'b0});
        // tap changes while holding: stg = 6,5,4,3,2,1,0...
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'h06, 1'b1, 5'd6, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd5, 8'h01, 1'b1, 5'd6, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd15, 8'h00, 1'b0, 5'd6, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd6, 8'h00, 1'b0, 5'd6, 1'b0});
        // rot without en is still a hold
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 4'd0, 8'h06, 1'b1, 5'd6, 1'b0});
        // flush beats en
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 4'd0, 8'h00, 1'b0, 5'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd3, 8'h00, 1'b0, 5'd0, 1'b0});
        // stall: one shift then five disabled cycles with noisy din
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 4'd0, 8'hA5, 1'b1, 5'd1, 1'b0});
        for (int i = 0; i < 5; i++)
            vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 4'd0, 8'hA5, 1'b1, 5'd1, 1'b0});
        // rst together with flush and en
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b1, 4'd0, 8'h00, 1'b0, 5'd0, 1'b0});

        #2;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].en, vecs[i].rot,
                  vecs[i].din, vecs[i].dv, vecs[i].sel);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_dv,
                    vecs[i].e_fill, vecs[i].e_full);
        end

        // Fill and clamp: 20 shifts of 1..20 watching the last tap.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd15);
        step();
        for (int n = 1; n <= 20; n++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 8'(n), 1'b1, 4'd15);
            step();
            chk_all($sformatf("fill%0d", n),
                    (n >= 16) ? 8'(n - 15) : 8'h00,
                    (n >= 16),
                    (n >= 16) ? 5'd16 : 5'(n),
                    (n >= 16));
        end

        // Rotate: load 0x00..0x0F, then 16 rotations restore the chain.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd15);
        step();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 8'(i), 1'b1, 4'd15);
            step();
        end
        for (int r = 1; r <= 16; r++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 4'd15);
            step();
            chk_all($sformatf("rot%0d", r), 8'(15 - ((15 - r + 16) % 16)), 1'b1, 5'd16, 1'b1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        for (int k = 0; k < 16; k++) begin
            delay_sel = 4'(k);
            #1;
            chk($sformatf("rotscan.tap%0d", k), int'(dout), 15 - k);
            chk($sformatf("rotscan.vld%0d", k), int'(dout_valid), 1);
        end

        // Flush with rotate requested: everything clears.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 4'd0);
        step();
        chk_all("flushrot", 8'h00, 1'b0, 5'd0, 1'b0);
        scan_zero("flushrot");

        // Reset mid-stream after 7 shifts discards everything buffered.
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h40 + i), 1'b1, 4'd0);
            step();
        end
        chk_all("pre_rst", 8'h46, 1'b1, 5'd7, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h99, 1'b1, 4'd0);
        step();
        chk_all("midrst", 8'h00, 1'b0, 5'd0, 1'b0);
        scan_zero("midrst");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 4'd0);
        step();
        chk_all("post_rst", 8'h3C, 1'b1, 5'd1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd1);
        #1;
        chk("post_rst.tap1", int'(dout), 0);
        chk("post_rst.vld1", int'(dout_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
